ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 10, meaning RAM word-address width.
REQ-002 The block SHALL have parameter DW, default 64, meaning RAM data width; byte-enable width is DW/8.
REQ-003 The block SHALL have port CLK, input, 1, the single clock.
REQ-004 The block SHALL have port RESETn, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have, per requester p in {0,1}, port Rp_REQ, input, 1, access request held until granted.
REQ-006 The block SHALL have, per p, port Rp_WE, input, DW/8, byte write enables; all-zero means read.
REQ-007 The block SHALL have, per p, port Rp_A, input, AW, word address.
REQ-008 The block SHALL have, per p, port Rp_DI, input, DW, write data.
REQ-009 The block SHALL have, per p, port Rp_GNT, output, 1, request accepted this cycle.
REQ-010 The block SHALL have, per p, port Rp_ACK, output, 1, completion pulse one cycle after grant.
REQ-011 The block SHALL have, per p, port Rp_DO, output, DW, read data, valid when Rp_ACK=1 for a read.
REQ-012 The block SHALL have RAM-side ports EN (output, 1), WE (output, DW/8), A (output, AW), Di (output, DW), Do (input, DW) matching the 1024x64 RAM macro.

Function
REQ-013 The block SHALL grant at most one requester per cycle; a request is granted in the cycle Rp_REQ=1 and Rp_GNT=1.
REQ-014 Rp_GNT SHALL be combinational from Rp_REQ and the priority pointer; no grant without request.
REQ-015 Arbitration SHALL be round-robin: a 1-bit pointer names the preferred requester; after any grant the pointer moves to the other requester; with no grant it holds.
REQ-016 Single requester asserting SHALL be granted every cycle (full throughput, one access/cycle).
REQ-017 Both asserting SHALL alternate grants 0,1,0,1... starting from the pointer value.
REQ-018 In a grant cycle EN=1 and WE, A, Di SHALL equal the granted requester's Rp_WE, Rp_A, Rp_DI; otherwise EN=0, WE=0, A=0, Di=0.
REQ-019 The block SHALL register {valid, port id, is_read} for each grant; next cycle it SHALL pulse Rp_ACK=1 for that port only.
REQ-020 For a read (Rp_WE=0) Rp_DO SHALL equal Do in the ACK cycle; for writes and non-ACK cycles Rp_DO SHALL be 0.
REQ-021 Back-to-back grants SHALL produce back-to-back ACKs with no bubble; ACK latency is exactly 1 cycle.
REQ-022 Requester inputs SHALL be ignored when not granted; a requester that drops Rp_REQ before grant is never granted.
REQ-023 Read after write to the same address on consecutive grants SHALL return the new data (RAM write-first ordering, no forwarding in this block).

Reset
REQ-024 RESETn=0 SHALL asynchronously clear the pointer to 0 (requester 0 preferred) and the pending-ACK register.
REQ-025 During reset all outputs SHALL be 0: Rp_GNT, Rp_ACK, Rp_DO, EN, WE, A, Di.
REQ-026 Reset asserted with an access pending SHALL drop it; no ACK is issued after reset release for pre-reset grants.

Structure
REQ-027 A shared package SHALL hold the requester-id type, the pending-ACK record type (valid, id, is_read) and constants AW=10, DW=64, N_REQ=2.
REQ-028 The round-robin pointer/grant logic SHALL be one sub-module, rr_arb2.

Verification
REQ-029 Reset release, R0 reads A=0x005 (preloaded 0xDEADBEEF_00C0FFEE) -> R0_GNT cycle 0, R0_ACK cycle 1, R0_DO=0xDEADBEEF_00C0FFEE.
REQ-030 R0 and R1 request continuously for 6 cycles -> grants 0,1,0,1,0,1; ACKs follow one cycle later in the same order.
REQ-031 R1 writes A=0x3FF, WE=0x0F, Di=0x11111111_22222222 over 0xFFFFFFFF_FFFFFFFF, then R1 reads 0x3FF -> R1_DO=0xFFFFFFFF_22222222.
REQ-032 R0 held at REQ=1 alone for 4 cycles -> 4 consecutive grants, 4 consecutive ACKs, EN=1 throughout.
REQ-033 RESETn pulsed low the cycle after an R1 read grant -> no R1_ACK, pointer=0, all outputs 0 during reset.
REQ-034 Idle (no REQ) -> EN=0, WE=0, A=0, Di=0 and no GNT/ACK.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: shared types and constants for the two-port RAM arbiter
package ram_port_arbiter_pkg;

    localparam int RAM_AW = 10;
    localparam int RAM_DW = 64;
    localparam int N_REQ  = 2;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
        logic    is_read;
    } pend_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with a 1-bit preferred-requester pointer
module rr_arb2 import ram_port_arbiter_pkg::*; (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_any,
    output req_id_t          gnt_id
);

    req_id_t ptr_q, ptr_d;

    // favour the pointed-to requester, fall back to the other; grant nothing while reset is held
    always_comb begin
        gnt_id  = req[ptr_q] ? ptr_q : ~ptr_q;
        gnt_any = rst_n & (|req);
        gnt     = gnt_any ? (N_REQ'(1) << gnt_id) : '0;
        ptr_d   = gnt_any ? ~gnt_id : ptr_q;
    end

    // pointer register, requester 0 preferred out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between two requesters with 1-cycle ACK
module ram_port_arbiter import ram_port_arbiter_pkg::*; #(
    parameter int AW = RAM_AW,
    parameter int DW = RAM_DW
) (
    input  logic            CLK,
    input  logic            RESETn,
    input  logic            R0_REQ,
    input  logic [DW/8-1:0] R0_WE,
    input  logic [AW-1:0]   R0_A,
    input  logic [DW-1:0]   R0_DI,
    output logic            R0_GNT,
    output logic            R0_ACK,
    output logic [DW-1:0]   R0_DO,
    input  logic            R1_REQ,
    input  logic [DW/8-1:0] R1_WE,
    input  logic [AW-1:0]   R1_A,
    input  logic [DW-1:0]   R1_DI,
    output logic            R1_GNT,
    output logic            R1_ACK,
    output logic [DW-1:0]   R1_DO,
    output logic            EN,
    output logic [DW/8-1:0] WE,
    output logic [AW-1:0]   A,
    output logic [DW-1:0]   Di,
    input  logic [DW-1:0]   Do
);

    logic [N_REQ-1:0] req, gnt;
    logic             gnt_any;
    req_id_t          gnt_id;
    pend_t            pend_q, pend_d;

    assign req = {R1_REQ, R0_REQ};

    rr_arb2 u_arb (
        .clk    (CLK),
        .rst_n  (RESETn),
        .req    (req),
        .gnt    (gnt),
        .gnt_any(gnt_any),
        .gnt_id (gnt_id)
    );

    // steer the granted requester onto the RAM port and record what the ACK must report
    always_comb begin
        R0_GNT         = gnt[0];
        R1_GNT         = gnt[1];
        EN             = gnt_any;
        WE             = gnt_any ? (gnt_id ? R1_WE : R0_WE) : '0;
        A              = gnt_any ? (gnt_id ? R1_A  : R0_A)  : '0;
        Di             = gnt_any ? (gnt_id ? R1_DI : R0_DI) : '0;
        pend_d.valid   = gnt_any;
        pend_d.id      = gnt_id;
        pend_d.is_read = gnt_any & ~(|WE);
    end

    // pending-ACK record, dropped immediately by reset
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) pend_q <= '0;
        else         pend_q <= pend_d;
    end

    // completion pulse to the owning port; read data only on a read ACK
    always_comb begin
        R0_ACK = pend_q.valid & (pend_q.id == 1'b0);
        R1_ACK = pend_q.valid & (pend_q.id == 1'b1);
        R0_DO  = (R0_ACK & pend_q.is_read) ? Do : '0;
        R1_DO  = (R1_ACK & pend_q.is_read) ? Do : '0;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed checks of arbitration, ACK timing, RAM steering and reset
module tb_ram_port_arbiter;

    localparam logic [63:0] D5  = 64'hDEADBEEF_00C0FFEE;
    localparam logic [63:0] DWR = 64'h11111111_22222222;
    localparam logic [63:0] DRB = 64'hFFFFFFFF_22222222;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b1;
    logic        R0_REQ = 1'b0, R1_REQ = 1'b0;
    logic [7:0]  R0_WE = '0, R1_WE = '0;
    logic [9:0]  R0_A = '0, R1_A = '0;
    logic [63:0] R0_DI = '0, R1_DI = '0;
    logic        R0_GNT, R1_GNT, R0_ACK, R1_ACK, EN;
    logic [63:0] R0_DO, R1_DO, Di, Do;
    logic [7:0]  WE;
    logic [9:0]  A;

    int checks = 0;
    int errors = 0;

    logic [63:0] mem [0:1023];
    logic [63:0] ram_w;

    ram_port_arbiter dut (
        .CLK(CLK), .RESETn(RESETn),
        .R0_REQ(R0_REQ), .R0_WE(R0_WE), .R0_A(R0_A), .R0_DI(R0_DI),
        .R0_GNT(R0_GNT), .R0_ACK(R0_ACK), .R0_DO(R0_DO),
        .R1_REQ(R1_REQ), .R1_WE(R1_WE), .R1_A(R1_A), .R1_DI(R1_DI),
        .R1_GNT(R1_GNT), .R1_ACK(R1_ACK), .R1_DO(R1_DO),
        .EN(EN), .WE(WE), .A(A), .Di(Di), .Do(Do)
    );

    always #5 CLK = ~CLK;

    // write-first synchronous RAM model with byte enables
    always @(posedge CLK) begin
        if (EN) begin
            ram_w = mem[A];
            for (int b = 0; b < 8; b++)
                if (WE[b]) ram_w[b*8 +: 8] = Di[b*8 +: 8];
            mem[A] <= ram_w;
            Do     <= ram_w;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next;
        @(posedge CLK);
        #1;
    endtask

    task automatic smp;
        @(negedge CLK);
    endtask

    task automatic chk_ram_idle(input string tag);
        chk({tag, "_en"}, 64'(EN), 64'd0);
        chk({tag, "_we"}, 64'(WE), 64'd0);
        chk({tag, "_a"},  64'(A),  64'd0);
        chk({tag, "_di"}, Di,      64'd0);
        chk({tag, "_g0"}, 64'(R0_GNT), 64'd0);
        chk({tag, "_g1"}, 64'(R1_GNT), 64'd0);
    endtask

    initial begin
        mem[10'h005] = D5;
        mem[10'h3FF] = 64'hFFFFFFFF_FFFFFFFF;
        #1;
        RESETn = 1'b0;
        R0_REQ = 1'b1; R0_WE = 8'hFF; R0_A = 10'h12; R0_DI = 64'h55;
        R1_REQ = 1'b1; R1_WE = 8'hF0; R1_A = 10'h34; R1_DI = 64'hAA;
        smp;
        chk_ram_idle("rst");
        chk("rst_ack0", 64'(R0_ACK), 64'd0);
        chk("rst_ack1", 64'(R1_ACK), 64'd0);
        chk("rst_do0",  R0_DO, 64'd0);
        chk("rst_do1",  R1_DO, 64'd0);
        next;
        RESETn = 1'b1;
        R0_REQ = 1'b0; R0_WE = '0; R0_A = '0; R0_DI = '0;
        R1_REQ = 1'b0; R1_WE = '0; R1_A = '0; R1_DI = '0;

        // R0 read of preloaded word right after reset
        next;
        R0_REQ = 1'b1; R0_A = 10'h005;
        smp;
        chk("rd0_g0", 64'(R0_GNT), 64'd1);
        chk("rd0_g1", 64'(R1_GNT), 64'd0);
        chk("rd0_en", 64'(EN), 64'd1);
        chk("rd0_a",  64'(A),  64'h005);
        chk("rd0_we", 64'(WE), 64'd0);
        next;
        R0_REQ = 1'b0; R0_A = '0;
        smp;
        chk("rd0_ack0", 64'(R0_ACK), 64'd1);
        chk("rd0_ack1", 64'(R1_ACK), 64'd0);
        chk("rd0_do",   R0_DO, D5);
        chk_ram_idle("idle1");

        // R1 partial write then read-back of the same word
        next;
        R1_REQ = 1'b1; R1_WE = 8'h0F; R1_A = 10'h3FF; R1_DI = DWR;
        smp;
        chk("wr1_g1", 64'(R1_GNT), 64'd1);
        chk("wr1_we", 64'(WE), 64'h0F);
        chk("wr1_a",  64'(A),  64'h3FF);
        chk("wr1_di", Di, DWR);
        next;
        R1_WE = 8'h00; R1_DI = '0;
        smp;
        chk("rb1_g1",    64'(R1_GNT), 64'd1);
        chk("wr1_ack1",  64'(R1_ACK), 64'd1);
        chk("wr1_do",    R1_DO, 64'd0);
        chk("rb1_we",    64'(WE), 64'd0);
        next;
        R1_REQ = 1'b0; R1_A = '0;
        smp;
        chk("rb1_ack1", 64'(R1_ACK), 64'd1);
        chk("rb1_do",   R1_DO, DRB);
        chk("rb1_en",   64'(EN), 64'd0);

        // both requesting: alternate 0,1,0,1,0,1 with ACKs one cycle behind
        for (int i = 0; i < 6; i++) begin
            next;
            R0_REQ = 1'b1; R0_A = 10'h005;
            R1_REQ = 1'b1; R1_A = 10'h3FF;
            smp;
            chk($sformatf("rr%0d_g0", i), 64'(R0_GNT), 64'(i % 2 == 0));
            chk($sformatf("rr%0d_g1", i), 64'(R1_GNT), 64'(i % 2 == 1));
            chk($sformatf("rr%0d_a", i),  64'(A), (i % 2 == 0) ? 64'h005 : 64'h3FF);
            chk($sformatf("rr%0d_ack0", i), 64'(R0_ACK), 64'(i > 0 && i % 2 == 1));
            chk($sformatf("rr%0d_ack1", i), 64'(R1_ACK), 64'(i > 0 && i % 2 == 0));
            chk($sformatf("rr%0d_do0", i), R0_DO, (i > 0 && i % 2 == 1) ? D5 : 64'd0);
            chk($sformatf("rr%0d_do1", i), R1_DO, (i > 0 && i % 2 == 0) ? DRB : 64'd0);
        end
        next;
        R0_REQ = 1'b0; R1_REQ = 1'b0; R0_A = '0; R1_A = '0;
        smp;
        chk("rr_tail_ack0", 64'(R0_ACK), 64'd0);
        chk("rr_tail_ack1", 64'(R1_ACK), 64'd1);
        chk("rr_tail_do1",  R1_DO, DRB);

        // R0 alone for 4 cycles; idle R1 inputs must not leak onto the RAM port
        R1_WE = 8'hFF; R1_A = 10'h155; R1_DI = 64'hBAD;
        for (int i = 0; i < 4; i++) begin
            next;
            R0_REQ = 1'b1; R0_A = 10'h005;
            smp;
            chk($sformatf("solo%0d_g0", i), 64'(R0_GNT), 64'd1);
            chk($sformatf("solo%0d_g1", i), 64'(R1_GNT), 64'd0);
            chk($sformatf("solo%0d_en", i), 64'(EN), 64'd1);
            chk($sformatf("solo%0d_a", i),  64'(A),  64'h005);
            chk($sformatf("solo%0d_we", i), 64'(WE), 64'd0);
            chk($sformatf("solo%0d_ack0", i), 64'(R0_ACK), 64'(i > 0));
            chk($sformatf("solo%0d_do0", i), R0_DO, (i > 0) ? D5 : 64'd0);
        end
        next;
        R0_REQ = 1'b0; R0_A = '0;
        smp;
        chk("solo_tail_ack0", 64'(R0_ACK), 64'd1);
        chk("solo_tail_do0",  R0_DO, D5);
        chk("solo_tail_en",   64'(EN), 64'd0);
        R1_WE = '0; R1_A = '0; R1_DI = '0;

        // R1 read granted, reset pulsed the following cycle: its ACK must vanish
        next;
        R1_REQ = 1'b1; R1_A = 10'h3FF;
        smp;
        chk("rst1_g1", 64'(R1_GNT), 64'd1);
        next;
        R1_REQ = 1'b0; R1_A = '0;
        R0_REQ = 1'b1; R0_WE = 8'hFF; R0_A = 10'h001; R0_DI = 64'h77;
        RESETn = 1'b0;
        smp;
        chk("rst1_ack1", 64'(R1_ACK), 64'd0);
        chk("rst1_do1",  R1_DO, 64'd0);
        chk("rst1_ack0", 64'(R0_ACK), 64'd0);
        chk_ram_idle("rst1");
        next;
        RESETn = 1'b1;
        R0_REQ = 1'b0; R0_WE = '0; R0_A = '0; R0_DI = '0;
        smp;
        chk("post1_ack1", 64'(R1_ACK), 64'd0);
        chk("post1_ack0", 64'(R0_ACK), 64'd0);

        // R0 grant moves pointer to 1; reset must bring it back to 0
        next;
        R0_REQ = 1'b1; R0_A = 10'h005;
        smp;
        chk("pre2_g0", 64'(R0_GNT), 64'd1);
        next;
        R0_REQ = 1'b0; R0_A = '0;
        RESETn = 1'b0;
        smp;
        chk("rst2_ack0", 64'(R0_ACK), 64'd0);
        next;
        RESETn = 1'b1;
        R0_REQ = 1'b1; R0_A = 10'h005;
        R1_REQ = 1'b1; R1_A = 10'h3FF;
        smp;
        chk("ptr_g0", 64'(R0_GNT), 64'd1);
        chk("ptr_g1", 64'(R1_GNT), 64'd0);
        next;
        R0_REQ = 1'b0; R1_REQ = 1'b0; R0_A = '0; R1_A = '0;
        smp;
        chk("ptr_ack0", 64'(R0_ACK), 64'd1);
        chk("ptr_do0",  R0_DO, D5);

        // fully idle
        next;
        smp;
        chk_ram_idle("idle2");
        chk("idle2_ack0", 64'(R0_ACK), 64'd0);
        chk("idle2_ack1", 64'(R1_ACK), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
